// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter.
// Access sizes and byte-lane masks used by the arbiter and lane formatter.
package ram_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_LO   = 4'b0011;
    localparam logic [3:0] LANE_HI   = 4'b1100;
    localparam logic [3:0] LANE_ALL  = 4'b1111;

    function automatic logic [3:0] byte_lane(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester port of the RAM arbiter.
// The requester drives the master side; the arbiter takes the slave side.
interface ram_port_arbiter_if #(
    parameter int AW = 10
);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;

    modport master (
        output req, we, size, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ram_port_arbiter_lane_fmt.sv
// Byte-lane formatter: lane enables, store replication,
// alignment check and load-lane extraction for one access.
module ram_lane_fmt
    import ram_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_result,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic [31:0] rdata
);

    always_comb begin
        sel        = LANE_ALL;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        rdata      = ram_result;
        unique case (1'b1)
            size == SZ_BYTE: begin
                sel       = byte_lane(addr_lo);
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {24'h0, ram_result[{addr_lo, 3'b000} +: 8]};
            end
            size == SZ_HALF: begin
                sel        = addr_lo[1] ? LANE_HI : LANE_LO;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
                rdata      = addr_lo[1] ? {16'h0, ram_result[31:16]}
                                        : {16'h0, ram_result[15:0]};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter onto one byte-laned RAM; responses one cycle after grant.
// Define RAM_ARB_RR_EN for round-robin on contention instead of fixed priority.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int A_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     a,
    ram_port_arbiter_if.slave     b,
    output logic                  ram_str,
    output logic [3:0]            ram_sel,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_data,
    input  logic [31:0]           ram_result
);

    logic                  pick_a;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  any_gnt;
    logic                  w_we;
    logic [1:0]            w_size;
    logic [ADDR_WIDTH+1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            f_sel;
    logic [31:0]           f_wdata;
    logic                  f_mis;
    logic [31:0]           f_rdata;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  a_err_q, a_err_d;
    logic [31:0]           a_rdata_q, a_rdata_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic                  b_err_q, b_err_d;
    logic [31:0]           b_rdata_q, b_rdata_d;

`ifdef RAM_ARB_RR_EN
    logic last_b_q, last_b_d;

    // The port that did not win most recently wins a tie.
    always_comb begin
        pick_a   = a.req & (~b.req | last_b_q);
        last_b_d = gnt_b ? 1'b1 : (gnt_a ? 1'b0 : last_b_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_b_q <= 1'b1;
        else      last_b_q <= last_b_d;
    end
`else
    localparam logic A_WINS = (A_PRIORITY != 0);

    always_comb pick_a = a.req & (~b.req | A_WINS);
`endif

    always_comb begin
        gnt_a   = rst & pick_a;
        gnt_b   = rst & b.req & ~pick_a;
        any_gnt = gnt_a | gnt_b;
        w_we    = pick_a ? a.we    : b.we;
        w_size  = pick_a ? a.size  : b.size;
        w_addr  = pick_a ? a.addr  : b.addr;
        w_wdata = pick_a ? a.wdata : b.wdata;
    end

    ram_lane_fmt u_fmt (
        .size       (w_size),
        .addr_lo    (w_addr[1:0]),
        .wdata      (w_wdata),
        .ram_result (ram_result),
        .sel        (f_sel),
        .wdata_rep  (f_wdata),
        .misaligned (f_mis),
        .rdata      (f_rdata)
    );

    // Idle cycles keep address/data parked to avoid toggling the RAM bus.
    always_comb begin
        addr_d   = any_gnt ? w_addr[ADDR_WIDTH+1:2] : addr_q;
        data_d   = any_gnt ? f_wdata : data_q;
        ram_addr = addr_d;
        ram_data = data_d;
        ram_sel  = any_gnt ? f_sel : LANE_NONE;
        ram_str  = any_gnt & w_we & ~f_mis;
    end

    always_comb begin
        a_rvalid_d = gnt_a;
        a_err_d    = gnt_a & f_mis;
        a_rdata_d  = (gnt_a & ~w_we & ~f_mis) ? f_rdata : 32'h0;
        b_rvalid_d = gnt_b;
        b_err_d    = gnt_b & f_mis;
        b_rdata_d  = (gnt_b & ~w_we & ~f_mis) ? f_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            data_q     <= '0;
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            a_rvalid_q <= a_rvalid_d;
            a_err_q    <= a_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_err_q    <= b_err_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a.gnt    = gnt_a;
    assign a.rvalid = a_rvalid_q;
    assign a.err    = a_err_q;
    assign a.rdata  = a_rdata_q;
    assign b.gnt    = gnt_b;
    assign b.rvalid = b_rvalid_q;
    assign b.err    = b_err_q;
    assign b.rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: byte-addressed reference memory model,
// directed scenarios with literal checks, then randomized traffic.
module tb_ram_port_arbiter;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(AW)) a_if ();
    ram_port_arbiter_if #(.AW(AW)) b_if ();

    logic          ram_str;
    logic [3:0]    ram_sel;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic [31:0]   ram_result;

    ram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .A_PRIORITY (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a_if),
        .b          (b_if),
        .ram_str    (ram_str),
        .ram_sel    (ram_sel),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_result (ram_result)
    );

    logic [31:0] ram [1024];
    assign ram_result = ram[ram_addr];

    always @(posedge clk) begin
        if (ram_str) begin
            for (int l = 0; l < 4; l++)
                if (ram_sel[l]) ram[ram_addr][l*8 +: 8] <= ram_data[l*8 +: 8];
        end
    end

    logic [7:0] mem_m [4096];
    int tests = 0;
    int fails = 0;

    bit          last_b_m = 1'b1;
    bit          pv_a, pe_a, pv_b, pe_b;
    logic [31:0] pd_a, pd_b;
    bit          have_last;
    logic [31:0] last_addr, last_data;
    bit          g_a_m, g_b_m;

    bit          rst_v;
    bit          ar, awe, br, bwe;
    logic [1:0]  asz, bsz;
    logic [11:0] aad, bad;
    logic [31:0] awd, bwd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [3:0] exp_sel(input int n, input int off);
        return 4'(((1 << n) - 1) << (off - off % n));
    endfunction

    function automatic logic [31:0] exp_rep(input int n, input logic [31:0] wd);
        longint lo;
        lo = (n == 4) ? longint'(wd) : longint'(wd) % (64'd1 << (8 * n));
        if (n == 1) return 32'(lo * 32'h01010101);
        if (n == 2) return 32'(lo * 32'h00010001);
        return 32'(lo);
    endfunction

    function automatic logic [31:0] load_m(input logic [11:0] ad, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(mem_m[(int'(ad) + i) % 4096]) << (8 * i));
        return v;
    endfunction

    task automatic step();
        bit          ga, gb, wwe, mis;
        logic [1:0]  wsz;
        logic [11:0] wad;
        logic [31:0] wwd;
        int          n;
        @(negedge clk);
        rst = rst_v;
        a_if.req = ar; a_if.we = awe; a_if.size = asz;
        a_if.addr = aad; a_if.wdata = awd;
        b_if.req = br; b_if.we = bwe; b_if.size = bsz;
        b_if.addr = bad; b_if.wdata = bwd;
        #1;
        if (!rst_v) begin
            pv_a = 0; pe_a = 0; pd_a = 0;
            pv_b = 0; pe_b = 0; pd_b = 0;
            have_last = 0;
        end
`ifdef RAM_ARB_RR_EN
        ga = rst_v && ar && (!br || last_b_m);
`else
        ga = rst_v && ar;
`endif
        gb = rst_v && br && !ga;
        wwe = ga ? awe : bwe;
        wsz = ga ? asz : bsz;
        wad = ga ? aad : bad;
        wwd = ga ? awd : bwd;
        n   = nbytes(wsz);
        mis = (int'(wad) % n) != 0;

        chk("a_gnt", 32'(a_if.gnt), 32'(ga));
        chk("b_gnt", 32'(b_if.gnt), 32'(gb));
        chk("ram_str", 32'(ram_str), 32'((ga || gb) && wwe && !mis));
        chk("ram_sel", 32'(ram_sel),
            (ga || gb) ? 32'(exp_sel(n, int'(wad) % 4)) : 32'h0);
        if (ga || gb) begin
            chk("ram_addr", 32'(ram_addr), 32'(wad) / 4);
            chk("ram_data", ram_data, exp_rep(n, wwd));
        end else if (have_last) begin
            chk("ram_addr_hold", 32'(ram_addr), last_addr);
            chk("ram_data_hold", ram_data, last_data);
        end
        chk("a_rvalid", 32'(a_if.rvalid), 32'(pv_a));
        chk("a_err", 32'(a_if.err), 32'(pe_a));
        chk("a_rdata", a_if.rdata, pd_a);
        chk("b_rvalid", 32'(b_if.rvalid), 32'(pv_b));
        chk("b_err", 32'(b_if.err), 32'(pe_b));
        chk("b_rdata", b_if.rdata, pd_b);

        if (!rst_v) begin
            last_b_m = 1'b1;
        end else begin
            pv_a = ga; pe_a = ga && mis;
            pd_a = (ga && !wwe && !mis) ? load_m(wad, n) : 32'h0;
            pv_b = gb; pe_b = gb && mis;
            pd_b = (gb && !wwe && !mis) ? load_m(wad, n) : 32'h0;
            if (ga || gb) begin
                have_last = 1;
                last_addr = 32'(wad) / 4;
                last_data = exp_rep(n, wwd);
                last_b_m  = gb;
            end
            if ((ga || gb) && wwe && !mis)
                for (int i = 0; i < n; i++)
                    mem_m[(int'(wad) + i) % 4096] = wwd[8*i +: 8];
        end
        g_a_m = ga;
        g_b_m = gb;
    endtask

    task automatic set_a(input bit r, input bit we, input logic [1:0] sz,
                         input logic [11:0] ad, input logic [31:0] wd);
        ar = r; awe = we; asz = sz; aad = ad; awd = wd;
    endtask

    task automatic set_b(input bit r, input bit we, input logic [1:0] sz,
                         input logic [11:0] ad, input logic [31:0] wd);
        br = r; bwe = we; bsz = sz; bad = ad; bwd = wd;
    endtask

    // mode 0: random, 1: both forced to request, 2: only held requests remain
    task automatic gen(input int mode);
        if (!ar || g_a_m) begin
            ar  = (mode == 1) ? 1'b1 : ((mode == 2) ? 1'b0 : ($urandom % 3 != 0));
            awe = 1'($urandom % 2);
            asz = 2'($urandom % 4);
            aad = 12'($urandom % 64);
            awd = $urandom;
        end
        if (!br || g_b_m) begin
            br  = (mode == 1) ? 1'b1 : ((mode == 2) ? 1'b0 : ($urandom % 3 != 0));
            bwe = 1'($urandom % 2);
            bsz = 2'($urandom % 4);
            bad = 12'($urandom % 64);
            bwd = $urandom;
        end
        step();
    endtask

    initial begin
        logic [3:0] exp_cont;
        for (int w = 0; w < 1024; w++) begin
            ram[w] = $urandom;
            for (int l = 0; l < 4; l++) mem_m[w*4 + l] = ram[w][l*8 +: 8];
        end
        rst_v = 0;
        set_a(0, 0, 2'b00, 12'h0, 32'h0);
        set_b(0, 0, 2'b00, 12'h0, 32'h0);
        step();
        chk("rst_a_rvalid", 32'(a_if.rvalid), 32'h0);
        chk("rst_b_rdata", b_if.rdata, 32'h0);
        step();
        rst_v = 1;

        set_a(1, 1, 2'b10, 12'h008, 32'hDEADBEEF);
        step();
        chk("t1_addr", 32'(ram_addr), 32'd2);
        chk("t1_sel", 32'(ram_sel), 32'hF);
        chk("t1_str", 32'(ram_str), 32'h1);
        set_a(1, 0, 2'b10, 12'h008, 32'h0);
        step();
        set_a(1, 1, 2'b00, 12'h00C, 32'h0);
        step();
        chk("t1_rvalid", 32'(a_if.rvalid), 32'h1);
        chk("t1_rdata", a_if.rdata, 32'hDEADBEEF);
        chk("t1_err", 32'(a_if.err), 32'h0);

        set_a(1, 1, 2'b00, 12'h00D, 32'h0000005A);
        step();
        chk("t2_sel", 32'(ram_sel), 32'h2);
        chk("t2_data", ram_data, 32'h5A5A5A5A);
        set_a(1, 0, 2'b00, 12'h00D, 32'h0);
        step();
        set_a(1, 0, 2'b01, 12'h00C, 32'h0);
        step();
        chk("t2_byte", a_if.rdata, 32'h0000005A);
        set_a(1, 1, 2'b10, 12'h000, 32'h11223344);
        step();
        chk("t2_half", a_if.rdata, 32'h00005A00);

        set_a(1, 0, 2'b10, 12'h006, 32'h0);
        step();
        chk("t3_gnt_ld", 32'(a_if.gnt), 32'h1);
        set_a(1, 1, 2'b01, 12'h003, 32'h0000FFFF);
        step();
        chk("t3_gnt_st", 32'(a_if.gnt), 32'h1);
        chk("t3_str", 32'(ram_str), 32'h0);
        chk("t3_ld_err", 32'(a_if.err), 32'h1);
        chk("t3_ld_rdata", a_if.rdata, 32'h0);
        set_a(1, 0, 2'b10, 12'h000, 32'h0);
        step();
        chk("t3_st_err", 32'(a_if.err), 32'h1);
        set_a(0, 0, 2'b00, 12'h000, 32'h0);
        step();
        chk("t3_unchanged", a_if.rdata, 32'h11223344);

        set_b(1, 0, 2'b10, 12'h008, 32'h0);
        step();
        chk("t4_b_only", 32'(b_if.gnt), 32'h1);
`ifdef RAM_ARB_RR_EN
        exp_cont = 4'b0101;
`else
        exp_cont = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            gen(1);
            chk("t4_cont_a_gnt", 32'(a_if.gnt), 32'(exp_cont[i]));
        end
        repeat (4) gen(2);

        set_a(1, 0, 2'b10, 12'h008, 32'h0);
        set_b(0, 0, 2'b00, 12'h000, 32'h0);
        step();
        rst_v = 0;
        set_a(1, 1, 2'b10, 12'h010, 32'hCAFEF00D);
        step();
        chk("t5_rvalid", 32'(a_if.rvalid), 32'h0);
        chk("t5_rdata", a_if.rdata, 32'h0);
        chk("t5_gnt", 32'(a_if.gnt), 32'h0);
        chk("t5_str", 32'(ram_str), 32'h0);
        step();
        chk("t5_str2", 32'(ram_str), 32'h0);
        rst_v = 1;
        set_b(1, 0, 2'b10, 12'h008, 32'h0);
        step();
        chk("t5_first_a", 32'(a_if.gnt), 32'h1);
        repeat (3) gen(2);

        for (int c = 0; c < 600; c++) begin
            rst_v = ($urandom % 80 != 0);
            gen(0);
        end
        rst_v = 1;
        repeat (4) gen(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one word-organised, byte-laned data RAM between two requesters:
  - port A: pipeline MEM stage;
  - port B: debug/DMA loader.
- Per accepted request it does four things:
  - converts the byte address and access size into a word address and a 4-bit byte-lane strobe;
  - replicates store data across lanes;
  - returns lane-extracted load data one cycle later;
  - flags misaligned accesses.
- Sits between the CPU/loader and the RAM. The RAM has a combinational read, a write on the clock edge, and per-lane write enables.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width. Byte address width is ADDR_WIDTH+2.
- A_PRIORITY, 1, fixed-priority winner when both ports request in the same cycle: 1 = A, 0 = B.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request valid.
- a_we  in  1  port A store (1) / load (0).
- a_size  in  2  port A size: 00 byte, 01 half, 1x word.
- a_addr  in  ADDR_WIDTH+2  port A byte address.
- a_wdata  in  32  port A store data, right-aligned.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_rvalid  out  1  port A response valid (registered).
- a_rdata  out  32  port A load data, zero-extended, right-aligned.
- a_err  out  1  port A misaligned-access flag; valid with a_rvalid.
- b_req, b_we, b_size, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: identical to port A, for port B.
- ram_str  out  1  RAM write strobe.
- ram_sel  out  4  RAM byte-lane enables.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_data  out  32  RAM write data.
- ram_result  in  32  RAM combinational read data.

Behaviour:
- Reset (rst low, asynchronous):
  - outputs: all rvalid/err 0, all rdata 0;
  - internal state: last-winner register = B, so A wins first under round-robin;
  - the RAM is never strobed while rst is low.
  - A request present when reset asserts is dropped: no gnt, no response.
- Arbitration, cycle N:
  - exactly one of a_gnt/b_gnt is high if any req is high, else neither;
  - single requester always wins;
  - both requesting: A_PRIORITY decides, or round-robin if the feature is enabled;
  - the loser holds its request (req stays high, fields stable) until granted.
- RAM drive, cycle N:
  - ram_addr = winner addr[ADDR_WIDTH+1:2].
  - ram_sel:
    - byte: 1 << addr[1:0];
    - half: addr[1] ? 4'b1100 : 4'b0011;
    - word: 4'b1111.
  - ram_data:
    - byte: wdata[7:0] replicated ×4;
    - half: wdata[15:0] replicated ×2;
    - word: wdata.
  - ram_str = gnt & we & aligned.
  - With no grant: ram_str=0, ram_sel=0; addr/data are don't-care but are held at the last values to limit toggling.
- Alignment:
  - half is misaligned if addr[0]=1;
  - word is misaligned if addr[1:0]≠0;
  - byte is never misaligned.
  - A misaligned request is still granted (consumed), performs no write, and its load data is 0.
- Response, cycle N+1:
  - x_rvalid pulses for exactly one cycle for every grant, loads and stores alike;
  - x_err is set for misaligned accesses;
  - x_rdata = lane-extracted ram_result captured at the end of cycle N, zero-extended; 0 for stores and for errors.
- Throughput: one access per cycle total; back-to-back grants are allowed.
- Read-after-write to the same word in consecutive cycles returns the new data, because the write has landed before the next cycle's combinational read.
- Address wrap: upper address bits beyond ADDR_WIDTH+2 do not exist, so the RAM wraps naturally; no error is raised.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: on simultaneous requests, the port that did not win the most recent contended-or-uncontended grant wins; the last-winner register updates on every grant.
- Undefined: fixed priority per A_PRIORITY; the last-winner register is absent.

Decomposition:
- Shared package `ram_arb_pkg` holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - lane-mask constants.
- One natural sub-module, `ram_lane_fmt` (combinational, instantiated once), takes size/addr/wdata/ram_result and produces:
  - sel, replicated data, misaligned flag, extracted rdata (fed to the response register).

Test Plan:
- Word store then load, A only:
  - stimulus: a_addr=0x008, wdata=0xDEADBEEF, store; next cycle load same address;
  - expect: ram_addr=2, ram_sel=1111; load rvalid next cycle with rdata=0xDEADBEEF, err=0.
- Byte and half lanes:
  - stimulus: store byte 0x5A at 0x00D, then load byte 0x00D and load half 0x00C;
  - expect: store ram_sel=0010, ram_data=0x5A5A5A5A; byte load rdata=0x0000005A; half load rdata=0x00005A00 once the lane-0 byte is zeroed.
- Misaligned:
  - stimulus: word load at 0x006, then half store at 0x003;
  - expect: both granted; ram_str=0 on the store; rvalid with err=1 and rdata=0; RAM contents unchanged.
- Contention, both requesting for 4 cycles:
  - without RAM_ARB_RR_EN, A_PRIORITY=1: grants A,A,A,A while B is stalled with fields held;
  - with the macro: grants alternate A,B,A,B.
- Reset mid-operation:
  - stimulus: assert rst low while a_req is high and an rvalid is pending;
  - expect: rvalid/err/rdata go to 0 immediately; no ram_str while reset is low; the first grant after release goes to A.
